// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared FSM encoding and default width for the serial subtractor
package serial_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - combinational one-bit full subtractor cell (x - y - bin)
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a - b, LSB first, one bit per clock
// Optional signed overflow output enabled by SERIAL_SUB_OVERFLOW_EN.
module serial_subtractor
  import serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] diff_r;
  logic             bin_r;
  logic [CW-1:0]    cnt;
  logic             bit_d;
  logic             bit_bout;
  logic             last_bit;

  full_subtractor u_cell (
    .x    (a_sr[0]),
    .y    (b_sr[0]),
    .bin  (bin_r),
    .d    (bit_d),
    .bout (bit_bout)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // diff fills from the MSB end, so after WIDTH shifts bit 0 holds the LSB result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      diff_r <= '0;
      bin_r  <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            bin_r <= 1'b0;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          diff_r <= {bit_d, diff_r[WIDTH-1:1]};
          bin_r  <= bit_bout;
          cnt    <= cnt + CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign diff   = diff_r;
  assign borrow = bin_r;

`ifdef SERIAL_SUB_OVERFLOW_EN
  logic ovf_r;

  // On the last bit the shift registers hold the operand sign bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_r <= 1'b0;
    end else if (state == RUN && last_bit) begin
      ovf_r <= (a_sr[0] ^ b_sr[0]) & (bit_d ^ a_sr[0]);
    end
  end

  assign overflow = ovf_r;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor
module tb_serial_subtractor;

  localparam int W = 8;
  localparam int P = W + 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic         overflow;
`endif

  int checks = 0;
  int errors = 0;
  int done_count = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .diff     (diff),
    .borrow   (borrow)
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    .overflow (overflow)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done === 1'b1) done_count++;
    checks++;
    assert (!(busy === 1'b1 && done === 1'b1)) else begin
      errors++;
      $error("FAIL busy_done_exclusive: observed busy=%b done=%b expected not both", busy, done);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    longint ux, uy, m;
    logic [W-1:0] r;
    ux = longint'(x);
    uy = longint'(y);
    m  = longint'(1) << W;
    r  = W'((ux - uy + m) % m);
    return {(ux < uy), r};
  endfunction

`ifdef SERIAL_SUB_OVERFLOW_EN
  function automatic logic model_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx, sy, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    r  = sx - sy;
    return (r > (longint'(1) << (W - 1)) - 1) || (r < -(longint'(1) << (W - 1)));
  endfunction
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y);
    int lat;
    int nbusy;
    logic [W:0] exp;
    exp   = model(x, y);
    a     = x;
    b     = y;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat   = 0;
    nbusy = 0;
    while (done !== 1'b1 && lat < 4 * W) begin
      if (busy === 1'b1) nbusy++;
      tick();
      lat++;
    end
    check({tag, " latency"}, lat, W);
    check({tag, " busy_cycles"}, nbusy, W);
    check({tag, " diff"}, diff, exp[W-1:0]);
    check({tag, " borrow"}, borrow, exp[W]);
`ifdef SERIAL_SUB_OVERFLOW_EN
    check({tag, " overflow"}, overflow, model_ovf(x, y));
`endif
    tick();
    check({tag, " done_one_cycle"}, done, 1'b0);
    check({tag, " idle_not_busy"}, busy, 1'b0);
    check({tag, " diff_held"}, diff, exp[W-1:0]);
    check({tag, " borrow_held"}, borrow, exp[W]);
  endtask

  initial begin
    logic [W:0]     exp;
    logic [2*W-1:0] q[$];
    logic [2*W-1:0] ops;
    int dc0;
    int lat;

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #2;
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset diff", diff, '0);
    check("reset borrow", borrow, 1'b0);
`ifdef SERIAL_SUB_OVERFLOW_EN
    check("reset overflow", overflow, 1'b0);
`endif
    tick();
    tick();
    rst = 1'b0;

    run_op("5-3", 8'h05, 8'h03);
    run_op("3-5", 8'h03, 8'h05);
    run_op("00-FF", 8'h00, 8'hFF);
    run_op("80-01", 8'h80, 8'h01);
    run_op("05-03", 8'h05, 8'h03);
    run_op("FF-FF", 8'hFF, 8'hFF);
    run_op("00-00", 8'h00, 8'h00);
    run_op("7F-80", 8'h7F, 8'h80);

    // start pulsed mid-RUN with new operands must be ignored
    dc0   = done_count;
    a     = 8'h10;
    b     = 8'h01;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    a     = 8'hAA;
    b     = 8'h11;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat   = 0;
    while (done !== 1'b1 && lat < 4 * W) begin
      tick();
      lat++;
    end
    check("ignore_start diff", diff, 8'h0F);
    check("ignore_start borrow", borrow, 1'b0);
    repeat (P + 2) tick();
    check("ignore_start single_done", done_count - dc0, 1);

    // reset in the 4th RUN cycle
    a     = 8'h5A;
    b     = 8'h33;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check("pre_reset busy", busy, 1'b1);
    dc0 = done_count;
    #2;
    rst = 1'b1;
    #1;
    check("midrun_reset busy", busy, 1'b0);
    check("midrun_reset done", done, 1'b0);
    check("midrun_reset diff", diff, '0);
    check("midrun_reset borrow", borrow, 1'b0);
    tick();
    rst = 1'b0;
    repeat (P) tick();
    check("midrun_reset no_done", done_count - dc0, 0);
    run_op("after_reset", 8'h5A, 8'h33);

    // start held high: accepts every P edges, operands sampled at each accept
    a     = 8'($urandom);
    b     = 8'($urandom);
    start = 1'b1;
    for (int k = 0; k < 4 * P; k++) begin
      if (k % P == 0) q.push_back({a, b});
      tick();
      check("b2b done_timing", done, (k % P == W));
      if (done === 1'b1 && q.size() > 0) begin
        ops = q.pop_front();
        exp = model(ops[2*W-1:W], ops[W-1:0]);
        check("b2b diff", diff, exp[W-1:0]);
        check("b2b borrow", borrow, exp[W]);
      end
      a = 8'($urandom);
      b = 8'($urandom);
    end
    start = 1'b0;
    check("b2b all_results", q.size(), 0);
    tick();

    for (int i = 0; i < 12; i++) begin
      run_op("random", 8'($urandom), 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
